// File: rtl/stencil_host_sequencer.sv
// Host-side initiator for the stencil solver pin protocol: turns single-word
// commands into registered solver pin cycles and returns READ data.
module stencil_host_sequencer #(
   parameter int unsigned CELLS   = 64,
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned TEMP_W  = 4,
   parameter int unsigned SWEEP_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [ADDR_W-1:0]  cmd_addr,
   input  logic [TEMP_W-1:0]  cmd_data,
   input  logic [SWEEP_W-1:0] cmd_count,
   input  logic               abort,
   output logic               rsp_valid,
   output logic [TEMP_W-1:0]  rsp_data,
   output logic               busy,
   output logic [SWEEP_W-1:0] sweeps_done,
   output logic               err,
   output logic [7:0]         sol_ui,
   output logic [7:0]         sol_uio_in,
   input  logic [7:0]         sol_uio_out,
   input  logic [7:0]         sol_uio_oe
);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_CONFIG, S_RUN, S_RD_ADDR, S_RD_SAMPLE
   } state_t;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0, OP_CONFIG = 2'd1, OP_RUN = 2'd2, OP_READ = 2'd3
   } op_t;

   localparam logic [ADDR_W-1:0] LP_LAST_CELL = ADDR_W'(CELLS - 1);
   localparam logic [7:0]        LP_IDLE_UI   = 8'h80;

   state_t               r_state, w_state_nxt;
   logic [7:0]           r_sol_ui, w_sol_ui_nxt;
   logic [7:0]           r_sol_uio_in, w_sol_uio_in_nxt;
   logic                 r_cmd_ready;
   logic                 r_rsp_valid, w_rsp_valid_nxt;
   logic [TEMP_W-1:0]    r_rsp_data, w_rsp_data_nxt;
   logic [SWEEP_W-1:0]   r_sweeps, w_sweeps_nxt;
   logic                 r_err, w_err_nxt;
   logic [ADDR_W-1:0]    r_cell, w_cell_nxt;
   logic [SWEEP_W-1:0]   r_remain, w_remain_nxt;
   logic                 r_abort, w_abort_nxt;

   logic w_accept, w_wrap, w_run_last, w_unused_uio;

   assign w_accept   = cmd_valid & r_cmd_ready & (r_state == S_IDLE);
   assign w_wrap     = (r_cell == LP_LAST_CELL);
   // A zero-count RUN leaves r_remain at 0; otherwise RUN only ends on a wrap
   // so the solver's cell index is back at 0.
   assign w_run_last = (r_remain == '0) |
                       (w_wrap & ((r_remain == SWEEP_W'(1)) | r_abort | abort));
   assign w_unused_uio = ^sol_uio_out[7:TEMP_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (cmd_op)
                  OP_WRITE:  w_state_nxt = S_WRITE;
                  OP_CONFIG: w_state_nxt = S_CONFIG;
                  OP_RUN:    w_state_nxt = S_RUN;
                  default:   w_state_nxt = S_RD_ADDR;
               endcase
            end
         end
         S_WRITE, S_CONFIG: w_state_nxt = S_IDLE;
         S_RUN:             if (w_run_last) w_state_nxt = S_IDLE;
         S_RD_ADDR:         w_state_nxt = S_RD_SAMPLE;
         S_RD_SAMPLE:       w_state_nxt = S_IDLE;
         default:           w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_sol_ui_nxt     = LP_IDLE_UI;
      w_sol_uio_in_nxt = '0;
      w_rsp_valid_nxt  = 1'b0;
      w_rsp_data_nxt   = r_rsp_data;
      w_sweeps_nxt     = r_sweeps;
      w_err_nxt        = r_err;
      w_cell_nxt       = r_cell;
      w_remain_nxt     = r_remain;
      w_abort_nxt      = r_abort;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (cmd_op)
                  OP_WRITE: begin
                     w_sol_ui_nxt     = {2'b01, cmd_addr};
                     w_sol_uio_in_nxt = 8'(cmd_data);
                  end
                  OP_CONFIG: begin
                     w_sol_ui_nxt     = {2'b11, 5'b0, cmd_addr[0]};
                     w_sol_uio_in_nxt = 8'(cmd_data);
                  end
                  OP_RUN: begin
                     w_sweeps_nxt = '0;
                     w_remain_nxt = cmd_count;
                     w_cell_nxt   = '0;
                     w_abort_nxt  = 1'b0;
                     w_sol_ui_nxt = (cmd_count != '0) ? 8'h00 : LP_IDLE_UI;
                  end
                  default: w_sol_ui_nxt = {2'b10, cmd_addr};
               endcase
            end
         end
         S_RUN: begin
            if (r_remain != '0) begin
               w_cell_nxt = r_cell + ADDR_W'(1);
               if (abort) w_abort_nxt = 1'b1;
               if (w_wrap) begin
                  w_sweeps_nxt = r_sweeps + SWEEP_W'(1);
                  w_remain_nxt = r_remain - SWEEP_W'(1);
               end
            end
            if (!w_run_last) w_sol_ui_nxt = 8'h00;
         end
         S_RD_ADDR: begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = sol_uio_out[TEMP_W-1:0];
            if (sol_uio_oe != 8'hFF) w_err_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sol_ui     <= LP_IDLE_UI;
         r_sol_uio_in <= '0;
         r_cmd_ready  <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_sweeps     <= '0;
         r_err        <= 1'b0;
         r_cell       <= '0;
         r_remain     <= '0;
         r_abort      <= 1'b0;
      end else begin
         r_sol_ui     <= w_sol_ui_nxt;
         r_sol_uio_in <= w_sol_uio_in_nxt;
         r_cmd_ready  <= (w_state_nxt == S_IDLE);
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_data   <= w_rsp_data_nxt;
         r_sweeps     <= w_sweeps_nxt;
         r_err        <= w_err_nxt;
         r_cell       <= w_cell_nxt;
         r_remain     <= w_remain_nxt;
         r_abort      <= w_abort_nxt;
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign busy        = (r_state != S_IDLE);
   assign sweeps_done = r_sweeps;
   assign err         = r_err;
   assign sol_ui      = r_sol_ui;
   assign sol_uio_in  = r_sol_uio_in;

endmodule

// File: tb/tb_stencil_host_sequencer.sv
// Directed bench for stencil_host_sequencer with a small behavioural solver
// model on the pin side.
module tb_stencil_host_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [5:0]  cmd_addr;
   logic [3:0]  cmd_data;
   logic [15:0] cmd_count;
   logic        abort;
   logic        rsp_valid;
   logic [3:0]  rsp_data;
   logic        busy;
   logic [15:0] sweeps_done;
   logic        err;
   logic [7:0]  sol_ui;
   logic [7:0]  sol_uio_in;
   logic [7:0]  sol_uio_out;
   logic [7:0]  sol_uio_oe;
   logic        oe_bad;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   stencil_host_sequencer #(
      .CELLS(64), .ADDR_W(6), .TEMP_W(4), .SWEEP_W(16)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cmd_count(cmd_count), .abort(abort), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .busy(busy), .sweeps_done(sweeps_done), .err(err),
      .sol_ui(sol_ui), .sol_uio_in(sol_uio_in), .sol_uio_out(sol_uio_out),
      .sol_uio_oe(sol_uio_oe)
   );

   always #5 clk = ~clk;

   // Solver model: edge cells take the boundary value on a sweep, interior
   // cells take the neighbour average.
   logic [3:0] mem [64];
   logic [3:0] m_bound;
   logic [5:0] m_idx;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_idx   <= '0;
         m_bound <= '0;
         for (int i = 0; i < 64; i++) mem[i] <= '0;
      end else begin
         case (sol_ui[7:6])
            2'b01: mem[sol_ui[5:0]] <= sol_uio_in[3:0];
            2'b11: if (sol_ui[0]) m_bound <= sol_uio_in[3:0];
            2'b00: begin
               if (m_idx == 6'd0 || m_idx == 6'd63) mem[m_idx] <= m_bound;
               else mem[m_idx] <= 4'((5'(mem[m_idx - 6'd1]) + 5'(mem[m_idx + 6'd1])) >> 1);
               m_idx <= m_idx + 6'd1;
            end
            default: ;
         endcase
      end
   end

   assign sol_uio_out = (sol_ui[7:6] == 2'b10) ? {4'b0, mem[sol_ui[5:0]]} : 8'h00;
   assign sol_uio_oe  = oe_bad ? 8'h00 : 8'hFF;

   // Pin monitor: running totals, sampled at the edge the solver sees.
   int unsigned mon_n00  = 0;
   int unsigned mon_runs = 0;
   int unsigned mon_busy = 0;
   logic [7:0]  mon_prev = 8'h80;

   always @(posedge clk) begin
      if (!rst) begin
         if (sol_ui == 8'h00) mon_n00 <= mon_n00 + 1;
         if (sol_ui == 8'h00 && mon_prev != 8'h00) mon_runs <= mon_runs + 1;
         if (busy) mon_busy <= mon_busy + 1;
      end
      mon_prev <= sol_ui;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns at the negedge inside the first cycle of the issued op.
   task automatic issue(input logic [1:0] op, input logic [5:0] a,
                        input logic [3:0] d, input logic [15:0] c);
      int unsigned k = 0;
      while (!cmd_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("ready_wait", 32'(cmd_ready), 32'h1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_count = c;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int unsigned bound);
      for (int i = 0; i < int'(bound); i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk("idle_wait", 32'(busy), 32'h0);
   endtask

   task automatic read_cell(input logic [5:0] a, output logic vld, output logic [3:0] d);
      issue(2'd3, a, 4'h0, 16'd0);
      @(negedge clk);
      vld = rsp_valid;
      d   = rsp_data;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned b00, bruns, bbusy;
      logic        v;
      logic [3:0]  d;

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
      cmd_count = '0; abort = 1'b0; oe_bad = 1'b0;
      #2;
      chk("rst_ui", 32'(sol_ui), 32'h80);
      chk("rst_uio", 32'(sol_uio_in), 32'h0);
      chk("rst_ready", 32'(cmd_ready), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rsp", 32'(rsp_valid), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(cmd_ready), 32'h1);

      // WRITE then READ back
      issue(2'd0, 6'd9, 4'hA, 16'd0);
      chk("wr_ui", 32'(sol_ui), 32'h49);
      chk("wr_uio", 32'(sol_uio_in), 32'h0A);
      chk("wr_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("wr_ui_end", 32'(sol_ui), 32'h80);
      chk("wr_uio_end", 32'(sol_uio_in), 32'h00);
      issue(2'd3, 6'd9, 4'h0, 16'd0);
      chk("rd_ui", 32'(sol_ui), 32'h89);
      chk("rd_vld_early", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      chk("rd_vld", 32'(rsp_valid), 32'h1);
      chk("rd_data", 32'(rsp_data), 32'hA);
      @(negedge clk);
      chk("rd_vld_end", 32'(rsp_valid), 32'h0);
      chk("rd_data_hold", 32'(rsp_data), 32'hA);
      chk("rd_busy_end", 32'(busy), 32'h0);

      // CONFIG boundary, one sweep
      issue(2'd0, 6'd0, 4'h3, 16'd0);
      issue(2'd1, 6'd1, 4'hF, 16'd0);
      chk("cfg_ui", 32'(sol_ui), 32'hC1);
      chk("cfg_uio", 32'(sol_uio_in), 32'h0F);
      @(negedge clk);
      chk("cfg_ui_end", 32'(sol_ui), 32'h80);
      issue(2'd2, 6'd0, 4'h0, 16'd1);
      wait_idle(200);
      chk("run1_sweeps", 32'(sweeps_done), 32'd1);
      read_cell(6'd0, v, d);
      chk("edge0_vld", 32'(v), 32'h1);
      chk("edge0_data", 32'(d), 32'hF);
      read_cell(6'd63, v, d);
      chk("edge63_data", 32'(d), 32'hF);

      // RUN 3 and RUN 0
      b00 = mon_n00; bruns = mon_runs; bbusy = mon_busy;
      issue(2'd2, 6'd0, 4'h0, 16'd3);
      chk("run3_ui", 32'(sol_ui), 32'h00);
      chk("run3_ready", 32'(cmd_ready), 32'h0);
      wait_idle(400);
      chk("run3_n00", mon_n00 - b00, 32'd192);
      chk("run3_runs", mon_runs - bruns, 32'd1);
      chk("run3_busy", mon_busy - bbusy, 32'd192);
      chk("run3_sweeps", 32'(sweeps_done), 32'd3);
      b00 = mon_n00; bbusy = mon_busy;
      issue(2'd2, 6'd0, 4'h0, 16'd0);
      chk("run0_busy", 32'(busy), 32'h1);
      chk("run0_ui", 32'(sol_ui), 32'h80);
      @(negedge clk);
      chk("run0_idle", 32'(busy), 32'h0);
      chk("run0_n00", mon_n00 - b00, 32'd0);
      chk("run0_busycyc", mon_busy - bbusy, 32'd1);
      chk("run0_sweeps", 32'(sweeps_done), 32'd0);

      // RUN 5 with abort in cycle 70
      b00 = mon_n00; bruns = mon_runs; bbusy = mon_busy;
      issue(2'd2, 6'd0, 4'h0, 16'd5);
      repeat (69) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_idle(600);
      chk("abort_n00", mon_n00 - b00, 32'd128);
      chk("abort_runs", mon_runs - bruns, 32'd1);
      chk("abort_busy", mon_busy - bbusy, 32'd128);
      chk("abort_sweeps", 32'(sweeps_done), 32'd2);

      // abort outside RUN is ignored; stale abort does not carry over
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      b00 = mon_n00;
      issue(2'd2, 6'd0, 4'h0, 16'd2);
      wait_idle(400);
      chk("run2_n00", mon_n00 - b00, 32'd128);
      chk("run2_sweeps", 32'(sweeps_done), 32'd2);

      // bad uio_oe at READ sample
      issue(2'd0, 6'd9, 4'h6, 16'd0);
      oe_bad = 1'b1;
      read_cell(6'd9, v, d);
      oe_bad = 1'b0;
      chk("oe_vld", 32'(v), 32'h1);
      chk("oe_err", 32'(err), 32'h1);
      read_cell(6'd9, v, d);
      chk("oe_good_data", 32'(d), 32'h6);
      chk("err_sticky", 32'(err), 32'h1);

      // async reset mid-RUN
      issue(2'd2, 6'd0, 4'h0, 16'd3);
      repeat (40) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_ui", 32'(sol_ui), 32'h80);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_ready", 32'(cmd_ready), 32'h0);
      chk("arst_sweeps", 32'(sweeps_done), 32'd0);
      chk("arst_err", 32'(err), 32'h0);
      chk("arst_rsp_data", 32'(rsp_data), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_ready_after", 32'(cmd_ready), 32'h1);
      chk("arst_ui_after", 32'(sol_ui), 32'h80);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
